// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM boundary: result-source encodings,
// skid-buffer occupancy states and payload sizing / branch helpers.
package ex_mem_stage_pkg;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // alu_res + store_data + pc_plus4 + rd + reg_write/mem_read/mem_write + result_src
    function automatic int payload_width(input int data_w, input int reg_w);
        return 3 * data_w + reg_w + 5;
    endfunction

    function automatic logic is_taken(input logic is_branch, input logic is_jump,
                                      input logic cmp);
        return is_jump | (is_branch & cmp);
    endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer. Ready is a register derived from the
// next occupancy, so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf
    import ex_mem_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_r;
    skid_state_e  state_nxt_s;
    logic [W-1:0] head_r;
    logic [W-1:0] skid_r;
    logic [W-1:0] head_nxt_s;
    logic [W-1:0] skid_nxt_s;
    logic         ready_r;
    logic         accept_s;
    logic         release_s;

    assign accept_s  = in_valid & ready_r & ~flush;
    assign release_s = (state_r != SKID_EMPTY) & out_ready;

    // Occupancy next-state and data movement between head and skid slots
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = SKID_EMPTY;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        head_nxt_s  = in_data;
                        state_nxt_s = SKID_ONE;
                    end else begin
                        state_nxt_s = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && !release_s) begin
                        skid_nxt_s  = in_data;
                        state_nxt_s = SKID_FULL;
                    end else if (release_s && !accept_s) begin
                        state_nxt_s = SKID_EMPTY;
                    end else if (accept_s && release_s) begin
                        head_nxt_s  = in_data;
                        state_nxt_s = SKID_ONE;
                    end else begin
                        state_nxt_s = SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (release_s) begin
                        head_nxt_s  = skid_r;
                        state_nxt_s = SKID_ONE;
                    end else begin
                        state_nxt_s = SKID_FULL;
                    end
                end
                default: begin
                    state_nxt_s = SKID_EMPTY;
                end
            endcase
        end
    end

    // State, storage and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SKID_EMPTY;
            head_r  <= {W{1'b0}};
            skid_r  <= {W{1'b0}};
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_nxt_s;
            skid_r  <= skid_nxt_s;
            ready_r <= (state_nxt_s != SKID_FULL);
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = (state_r != SKID_EMPTY);
    assign out_data  = head_r;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: buffers the execute result through a skid buffer,
// raises a one-cycle registered redirect for taken branches/jumps, drives forwarding.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_alu_res,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_result_src,
    input  logic [DATA_WIDTH-1:0] ex_pc_plus4,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jump,
    input  logic [DATA_WIDTH-1:0] ex_target,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_alu_res,
    output logic [DATA_WIDTH-1:0] mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [1:0]            mem_result_src,
    output logic [DATA_WIDTH-1:0] mem_pc_plus4,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  load_hazard
);

    localparam int PAYLOAD_W = payload_width(DATA_WIDTH, REG_ADDR_W);

    logic [PAYLOAD_W-1:0]  in_payload_s;
    logic [PAYLOAD_W-1:0]  head_payload_s;
    logic                  accept_s;
    logic                  taken_s;
    logic                  redirect_valid_r;
    logic [DATA_WIDTH-1:0] redirect_pc_r;
    logic                  rd_live_s;

    assign in_payload_s = {ex_alu_res, ex_store_data, ex_rd, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_result_src, ex_pc_plus4};

    assign {mem_alu_res, mem_store_data, mem_rd, mem_reg_write,
            mem_mem_read, mem_mem_write, mem_result_src, mem_pc_plus4} = head_payload_s;

    pipe_skid_buf #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (ex_valid),
        .in_ready (ex_ready),
        .in_data  (in_payload_s),
        .out_valid(mem_valid),
        .out_ready(mem_ready),
        .out_data (head_payload_s)
    );

    assign accept_s = ex_valid & ex_ready;
    assign taken_s  = is_taken(ex_is_branch, ex_is_jump, ex_alu_res[0]);

    // One-cycle redirect pulse; a flushed accept never redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            redirect_valid_r <= 1'b0;
        end else begin
            redirect_valid_r <= accept_s & taken_s;
            if (accept_s && taken_s) begin
                redirect_pc_r <= ex_target;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

    // Forwarding looks only at the head entry; x0 writes are masked here
    always_comb begin
        rd_live_s   = mem_valid & mem_reg_write & (mem_rd != {REG_ADDR_W{1'b0}});
        fwd_valid   = rd_live_s & (mem_result_src != RESULT_SRC_MEM);
        fwd_rd      = mem_rd;
        load_hazard = rd_live_s & mem_mem_read;
        if (mem_result_src == RESULT_SRC_PC4) begin
            fwd_data = mem_pc_plus4;
        end else begin
            fwd_data = mem_alu_res;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_result_src;
    logic [31:0] ex_pc_plus4;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_target;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_result_src(ex_result_src), .ex_pc_plus4(ex_pc_plus4),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_target(ex_target),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_res(mem_alu_res), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
        .mem_pc_plus4(mem_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_hazard(load_hazard)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [1:0] src,
                          input logic [31:0] pc4, input logic br, input logic jp,
                          input logic [31:0] tgt);
        ex_valid      = v;
        ex_alu_res    = alu;
        ex_store_data = alu ^ 32'h0000_FFFF;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = 1'b0;
        ex_result_src = src;
        ex_pc_plus4   = pc4;
        ex_is_branch  = br;
        ex_is_jump    = jp;
        ex_target     = tgt;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b1;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_ex_ready", ex_ready, 1'b1);
        check("rst_redirect", redirect_valid, 1'b0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_alu_res", mem_alu_res, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        tick();

        // 1: single ALU op
        set_ex(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 2'b00, 32'h0000_0044, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t1_mem_valid", mem_valid, 1'b1);
        check("t1_mem_alu", mem_alu_res, 32'h5);
        check("t1_store", mem_store_data, 32'h0000_FFFA);
        check("t1_fwd_valid", fwd_valid, 1'b1);
        check("t1_fwd_rd", fwd_rd, 5'd3);
        check("t1_fwd_data", fwd_data, 32'h5);
        check("t1_ex_ready", ex_ready, 1'b1);
        tick();
        check("t1_drained", mem_valid, 1'b0);

        // 2: back-pressure, FIFO order
        mem_ready = 1'b0;
        set_ex(1'b1, 32'h0000_000A, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t2_a_head", mem_alu_res, 32'hA);
        check("t2_ready_one", ex_ready, 1'b1);
        set_ex(1'b1, 32'h0000_000B, 5'd5, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t2_ready_full", ex_ready, 1'b0);
        check("t2_a_stable", mem_alu_res, 32'hA);
        set_ex(1'b1, 32'h0000_000C, 5'd6, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t2_c_held_ready", ex_ready, 1'b0);
        check("t2_c_held_head", mem_alu_res, 32'hA);
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        mem_ready = 1'b1;
        tick();
        check("t2_b_head", mem_alu_res, 32'hB);
        check("t2_b_valid", mem_valid, 1'b1);
        check("t2_ready_back", ex_ready, 1'b1);
        tick();
        check("t2_empty", mem_valid, 1'b0);

        // 3: branch / jump redirect
        set_ex(1'b1, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0000_0100);
        tick();
        check("t3_redir_taken", redirect_valid, 1'b1);
        check("t3_redir_pc", redirect_pc, 32'h0000_0100);
        set_ex(1'b1, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0000_0200);
        tick();
        check("t3_not_taken", redirect_valid, 1'b0);
        check("t3_nt_valid", mem_valid, 1'b1);
        set_ex(1'b1, 32'h0000_0998, 5'd1, 1'b1, 1'b0, 2'b10, 32'h0000_0024, 1'b0, 1'b1, 32'h0000_0300);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t3_jal_redir", redirect_valid, 1'b1);
        check("t3_jal_pc", redirect_pc, 32'h0000_0300);
        check("t3_jal_fwd_valid", fwd_valid, 1'b1);
        check("t3_jal_fwd_data", fwd_data, 32'h0000_0024);
        tick();
        check("t3_pulse_end", redirect_valid, 1'b0);

        // 4: flush from FULL, and flush dropping an accept in ONE
        mem_ready = 1'b0;
        set_ex(1'b1, 32'h0000_0011, 5'd8, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b1, 32'h0000_0022, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t4_full", ex_ready, 1'b0);
        set_ex(1'b1, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0000_0400);
        flush = 1'b1;
        tick();
        check("t4_flush_valid", mem_valid, 1'b0);
        check("t4_flush_ready", ex_ready, 1'b1);
        check("t4_flush_redir", redirect_valid, 1'b0);
        flush = 1'b0;
        set_ex(1'b1, 32'h0000_0033, 5'd10, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t4_one", mem_valid, 1'b1);
        set_ex(1'b1, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0000_0440);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t4_drop_valid", mem_valid, 1'b0);
        check("t4_drop_redir", redirect_valid, 1'b0);
        check("t4_drop_ready", ex_ready, 1'b1);

        // 5: load hazard
        set_ex(1'b1, 32'h0000_1000, 5'd7, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("t5_hazard", load_hazard, 1'b1);
        check("t5_no_fwd", fwd_valid, 1'b0);
        mem_ready = 1'b1;
        set_ex(1'b1, 32'h0000_2000, 5'd0, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t5_rd0_valid", mem_valid, 1'b1);
        check("t5_rd0_passthru", mem_alu_res, 32'h0000_2000);
        check("t5_rd0_hazard", load_hazard, 1'b0);
        check("t5_rd0_fwd", fwd_valid, 1'b0);
        tick();

        // 6: async reset while FULL with a redirect pending
        mem_ready = 1'b0;
        set_ex(1'b1, 32'h0000_0055, 5'd2, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b1, 32'h0000_0066, 5'd3, 1'b1, 1'b0, 2'b10, 32'h8, 1'b0, 1'b1, 32'h0000_0500);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t6_pre_full", ex_ready, 1'b0);
        check("t6_pre_redir", redirect_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", mem_valid, 1'b0);
        check("t6_async_redir", redirect_valid, 1'b0);
        check("t6_async_ready", ex_ready, 1'b1);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("t6_after_ready", ex_ready, 1'b1);
        check("t6_after_valid", mem_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
